// File: rtl/ftdi_pkg.sv
// Shared constants and types for the FT245 synchronous-FIFO link.
package ftdi_pkg;

  localparam int unsigned PKT_LEN = 8;

  localparam logic [2:0] IDX_HDR0   = 3'd0;
  localparam logic [2:0] IDX_HDR1   = 3'd1;
  localparam logic [2:0] IDX_SEQ    = 3'd2;
  localparam logic [2:0] IDX_STATUS = 3'd3;
  localparam logic [2:0] IDX_FRM_HI = 3'd4;
  localparam logic [2:0] IDX_FRM_LO = 3'd5;
  localparam logic [2:0] IDX_DROP   = 3'd6;
  localparam logic [2:0] IDX_CHK    = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  localparam logic [7:0] HDR0_DEFAULT = 8'hA5;
  localparam logic [7:0] HDR1_DEFAULT = 8'h5A;

  typedef struct packed {
    logic [7:0]  seq;
    logic [7:0]  status;
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;
  } pkt_snap_t;

endpackage

// File: rtl/ftdi_tx_pktmux.sv
// Combinational byte select over the packet snapshot, including the XOR checksum.
module ftdi_tx_pktmux
  import ftdi_pkg::*;
#(
  parameter logic [7:0] HDR0 = HDR0_DEFAULT,
  parameter logic [7:0] HDR1 = HDR1_DEFAULT
) (
  input  pkt_snap_t  snap,
  input  logic [2:0] sel,
  output logic [7:0] byte_out
);

  logic [7:0] chk;

  assign chk = HDR0 ^ HDR1 ^ snap.seq ^ snap.status ^
               snap.frame_cnt[15:8] ^ snap.frame_cnt[7:0] ^ snap.drop_cnt;

  always_comb begin
    byte_out = '0;
    case (sel)
      IDX_HDR0:   byte_out = HDR0;
      IDX_HDR1:   byte_out = HDR1;
      IDX_SEQ:    byte_out = snap.seq;
      IDX_STATUS: byte_out = snap.status;
      IDX_FRM_HI: byte_out = snap.frame_cnt[15:8];
      IDX_FRM_LO: byte_out = snap.frame_cnt[7:0];
      IDX_DROP:   byte_out = snap.drop_cnt;
      IDX_CHK:    byte_out = chk;
      default:    byte_out = '0;
    endcase
  end

endmodule

// File: rtl/ftdi_tx.sv
// FT245 transmit side: sends fixed 8-byte status packets over the shared FTDI bus,
// arbitrating with the receiver via bus_req/bus_gnt and throttled by ftdi_txe_n.
module ftdi_tx
  import ftdi_pkg::*;
#(
  parameter logic [7:0] HDR0 = HDR0_DEFAULT,
  parameter logic [7:0] HDR1 = HDR1_DEFAULT
) (
  input  logic        clk_60,
  input  logic        rst,
  input  logic        report_req,
  input  logic [15:0] frame_cnt,
  input  logic [7:0]  status,
  input  logic        ftdi_txe_n,
  input  logic        bus_gnt,
  output logic        bus_req,
  output logic        ftdi_wr_n,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        busy
);

  logic [1:0] state;
  logic [2:0] idx;
  logic [7:0] seq;
  logic [7:0] drop_cnt;
  logic       pending;
  pkt_snap_t  snap;

  logic       start;
  logic       accept;
  logic [2:0] sel;
  logic [7:0] byte_sel;

  assign start  = (state == ST_IDLE) && (report_req || pending);
  assign accept = (state == ST_SEND) && !ftdi_wr_n && !ftdi_txe_n;
  // Look one byte ahead on acceptance so data_out is valid the cycle after the transfer.
  assign sel    = idx + {2'b00, accept};
  assign busy   = (state != ST_IDLE);

  ftdi_tx_pktmux #(
    .HDR0(HDR0),
    .HDR1(HDR1)
  ) u_pktmux (
    .snap    (snap),
    .sel     (sel),
    .byte_out(byte_sel)
  );

  always_ff @(posedge clk_60) begin
    if (!rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      seq       <= '0;
      drop_cnt  <= '0;
      pending   <= 1'b0;
      snap      <= '0;
      bus_req   <= 1'b0;
      ftdi_wr_n <= 1'b1;
      data_oe   <= 1'b0;
      data_out  <= '0;
    end else begin
      // A request landing while pending is still set counts as a drop, even on the snapshot edge.
      if (start) begin
        pending  <= 1'b0;
        drop_cnt <= (report_req && pending) ? 8'd1 : '0;
      end else if (report_req && (state != ST_IDLE)) begin
        if (!pending)
          pending <= 1'b1;
        else if (drop_cnt != '1)
          drop_cnt <= drop_cnt + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            snap    <= '{seq: seq, status: status, frame_cnt: frame_cnt, drop_cnt: drop_cnt};
            idx     <= '0;
            bus_req <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_gnt) begin
            state     <= ST_SEND;
            ftdi_wr_n <= 1'b0;
            data_oe   <= 1'b1;
            data_out  <= byte_sel;
          end
        end
        ST_SEND: begin
          if (accept)
            idx <= idx + 3'd1;
          if (accept && (idx == 3'(PKT_LEN - 1))) begin
            state     <= ST_IDLE;
            bus_req   <= 1'b0;
            ftdi_wr_n <= 1'b1;
            data_oe   <= 1'b0;
            data_out  <= '0;
            seq       <= seq + 8'd1;
          end else if (!bus_gnt) begin
            state     <= ST_REQ;
            ftdi_wr_n <= 1'b1;
            data_oe   <= 1'b0;
          end else begin
            data_out  <= byte_sel;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bus_req   <= 1'b0;
          ftdi_wr_n <= 1'b1;
          data_oe   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_tx.sv
// Bench for ftdi_tx: directed scenarios plus random bus traffic against a packet-level model.
module tb_ftdi_tx;

  logic        clk_60 = 1'b0;
  logic        rst;
  logic        report_req;
  logic [15:0] frame_cnt;
  logic [7:0]  status;
  logic        ftdi_txe_n;
  logic        bus_gnt;
  logic        bus_req;
  logic        ftdi_wr_n;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        busy;

  ftdi_tx #(
    .HDR0(8'hA5),
    .HDR1(8'h5A)
  ) dut (
    .clk_60    (clk_60),
    .rst       (rst),
    .report_req(report_req),
    .frame_cnt (frame_cnt),
    .status    (status),
    .ftdi_txe_n(ftdi_txe_n),
    .bus_gnt   (bus_gnt),
    .bus_req   (bus_req),
    .ftdi_wr_n (ftdi_wr_n),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .busy      (busy)
  );

  always #5 clk_60 = ~clk_60;

  int n_checks = 0;
  int n_errors = 0;

  // Packet-level reference model
  bit         m_active, m_pending;
  int         m_seq, m_drop, m_idx;
  logic [7:0] exp_pkt [8];
  logic [7:0] obs     [8];
  logic [7:0] last_pkt[8];
  int         pkts, cyc, start_edge, done_edge;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_pkt();
    logic [7:0] x;
    exp_pkt[0] = 8'hA5;
    exp_pkt[1] = 8'h5A;
    exp_pkt[2] = 8'(m_seq);
    exp_pkt[3] = status;
    exp_pkt[4] = frame_cnt[15:8];
    exp_pkt[5] = frame_cnt[7:0];
    exp_pkt[6] = 8'(m_drop);
    x = 8'h00;
    for (int i = 0; i < 7; i++) x = x ^ exp_pkt[i];
    exp_pkt[7] = x;
  endtask

  // One clock: inputs are already set; update model for the coming edge, then check after it.
  task automatic tick();
    bit was_active, acc, gnt_s, rst_s;
    acc        = (ftdi_wr_n === 1'b0) && (ftdi_txe_n == 1'b0);
    gnt_s      = bus_gnt;
    rst_s      = rst;
    was_active = m_active;
    if (!rst_s) begin
      m_active = 0; m_pending = 0; m_seq = 0; m_drop = 0; m_idx = 0;
    end else if (!was_active) begin
      if (acc) check_eq("spurious_wr", 1, 0);
      if (report_req || m_pending) begin
        build_pkt();
        m_drop     = (report_req && m_pending) ? 1 : 0;
        m_pending  = 0;
        m_active   = 1;
        m_idx      = 0;
        start_edge = cyc;
      end
    end else begin
      if (report_req) begin
        if (!m_pending) m_pending = 1;
        else if (m_drop < 255) m_drop++;
      end
      if (acc) begin
        check_eq($sformatf("byte%0d", m_idx), data_out, exp_pkt[m_idx]);
        obs[m_idx] = data_out;
        m_idx++;
        if (m_idx == 8) begin
          m_active  = 0;
          m_seq     = (m_seq + 1) % 256;
          pkts++;
          done_edge = cyc;
          last_pkt  = obs;
        end
      end
    end
    @(posedge clk_60);
    @(negedge clk_60);
    cyc++;
    if (rst_s) begin
      check_eq("busy_req", {busy, bus_req}, {m_active, m_active});
      check_eq("oe_vs_wr", data_oe, !ftdi_wr_n);
      if (!gnt_s) check_eq("gnt_release", {data_oe, ftdi_wr_n}, 2'b01);
    end
  endtask

  task automatic send_one(input logic [7:0] st, input logic [15:0] fc);
    status     = st;
    frame_cnt  = fc;
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int n = 0;
    while (pkts < target && n < budget) begin
      tick();
      n++;
    end
    check_eq("pkt_count", pkts, target);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    check_eq("rst_out", {bus_req, ftdi_wr_n, data_oe, data_out, busy}, {1'b0, 1'b1, 1'b0, 8'h00, 1'b0});
    rst = 1'b1;
  endtask

  initial begin
    int base, k;
    rst = 1'b0; report_req = 1'b0; frame_cnt = '0; status = '0;
    ftdi_txe_n = 1'b0; bus_gnt = 1'b1;
    m_active = 0; m_pending = 0; m_seq = 0; m_drop = 0; m_idx = 0;
    pkts = 0; cyc = 0; start_edge = 0; done_edge = 0;
    @(negedge clk_60);
    tick();
    do_reset();
    tick();

    // Basic packet and latency
    send_one(8'h3C, 16'h1234);
    wait_pkts(1, 20);
    check_eq("basic_b0", last_pkt[0], 8'hA5);
    check_eq("basic_b1", last_pkt[1], 8'h5A);
    check_eq("basic_seq", last_pkt[2], 8'h00);
    check_eq("basic_st", last_pkt[3], 8'h3C);
    check_eq("basic_fhi", last_pkt[4], 8'h12);
    check_eq("basic_flo", last_pkt[5], 8'h34);
    check_eq("basic_drop", last_pkt[6], 8'h00);
    check_eq("basic_chk", last_pkt[7], 8'hE5);
    check_eq("basic_lat", done_edge - start_edge, 9);
    tick();

    // txe_n stall for 3 cycles while byte 4 is on the bus
    status = 8'h11; frame_cnt = 16'hBEEF; report_req = 1'b1;
    for (k = 0; k < 20 && pkts < 2; k++) begin
      ftdi_txe_n = (k >= 6 && k <= 8);
      tick();
      report_req = 1'b0;
    end
    ftdi_txe_n = 1'b0;
    check_eq("stall_pkts", pkts, 2);
    check_eq("stall_seq", last_pkt[2], 8'h01);
    check_eq("stall_lat", done_edge - start_edge, 12);
    tick();

    // Grant loss for 5 cycles after byte 2
    status = 8'h77; frame_cnt = 16'h0F0F; report_req = 1'b1;
    for (k = 0; k < 30 && pkts < 3; k++) begin
      bus_gnt = !(k >= 5 && k <= 9);
      tick();
      report_req = 1'b0;
    end
    bus_gnt = 1'b1;
    check_eq("gnt_pkts", pkts, 3);
    check_eq("gnt_lat", done_edge - start_edge, 14);
    tick();

    // Overflow: three extra requests during one packet
    base = pkts;
    status = 8'h01; frame_cnt = 16'h0001; report_req = 1'b1;
    for (k = 0; k < 6; k++) begin
      tick();
      report_req = (k >= 1 && k <= 3);
    end
    report_req = 1'b0;
    wait_pkts(base + 1, 20);
    k = done_edge;
    wait_pkts(base + 2, 20);
    check_eq("pend_restart", start_edge - k, 1);
    check_eq("ovf_drop", last_pkt[6], 8'h02);
    tick();
    send_one(8'h02, 16'h0002);
    wait_pkts(base + 3, 20);
    check_eq("post_ovf_drop", last_pkt[6], 8'h00);
    tick();

    // Reset while byte 5 is being driven
    send_one(8'h55, 16'hAAAA);
    for (k = 0; k < 20 && m_idx < 5; k++) tick();
    check_eq("reach_b5", m_idx, 5);
    do_reset();
    tick();
    base = pkts;
    send_one(8'h66, 16'h1357);
    wait_pkts(base + 1, 20);
    check_eq("rst_seq", last_pkt[2], 8'h00);
    check_eq("rst_b0", last_pkt[0], 8'hA5);
    tick();

    // Drop counter saturation under a long grant outage with continuous requests
    base = pkts;
    send_one(8'h99, 16'h9999);
    bus_gnt = 1'b0;
    report_req = 1'b1;
    for (k = 0; k < 300; k++) tick();
    report_req = 1'b0;
    bus_gnt = 1'b1;
    wait_pkts(base + 2, 40);
    check_eq("sat_drop", last_pkt[6], 8'hFF);
    tick();

    // Sequence wrap over 256 packets
    do_reset();
    tick();
    base = pkts;
    for (int p = 0; p < 256; p++) begin
      send_one(8'($urandom), 16'($urandom));
      wait_pkts(base + p + 1, 20);
    end
    check_eq("seq_255", last_pkt[2], 8'hFF);
    send_one(8'h00, 16'h0000);
    wait_pkts(base + 257, 20);
    check_eq("seq_wrap", last_pkt[2], 8'h00);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      report_req = ($urandom_range(0, 7) == 0);
      status     = 8'($urandom);
      frame_cnt  = 16'($urandom);
      ftdi_txe_n = ($urandom_range(0, 3) == 0);
      bus_gnt    = ($urandom_range(0, 4) != 0);
      tick();
    end
    report_req = 1'b0; ftdi_txe_n = 1'b0; bus_gnt = 1'b1;
    for (k = 0; k < 60 && (m_active || m_pending); k++) tick();
    check_eq("drain", {m_active, m_pending}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
